monitor_rango_consecutivo: RTL and testbench

//  Downstream consumer of the 5-bit two's-complement range checker.

---
 rtl/monitor_rango_consecutivo_if.sv | 32 +++
 rtl/monitor_rango_consecutivo.sv | 154 +++++++++++++++
 tb/tb_monitor_rango_consecutivo.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/monitor_rango_consecutivo_if.sv
// Sample/flag input bundle and statistics/alarm outputs of the
// consecutive-outside-range monitor.
interface monitor_rango_consecutivo_if #(
    parameter int unsigned CNT_W = 8
);
    logic             muestra_valida;
    logic [4:0]       muestra;
    logic             dentro;
    logic             borrar;
    logic [CNT_W-1:0] cuenta_dentro;
    logic [CNT_W-1:0] cuenta_fuera;
    logic [3:0]       racha_fuera;
    logic [1:0]       estado;
    logic             alarma;
    logic [4:0]       minimo;
    logic [4:0]       maximo;
    logic             hay_datos;

    // Producer side: presents samples, observes the statistics.
    modport master (
        output muestra_valida, muestra, dentro, borrar,
        input  cuenta_dentro, cuenta_fuera, racha_fuera, estado, alarma,
               minimo, maximo, hay_datos
    );

    // Monitor side.
    modport slave (
        input  muestra_valida, muestra, dentro, borrar,
        output cuenta_dentro, cuenta_fuera, racha_fuera, estado, alarma,
               minimo, maximo, hay_datos
    );
endinterface

// File: rtl/monitor_rango_consecutivo.sv
// Consumes range-checker results: saturating inside/outside counts, signed
// min/max tracking, and a NORMAL/ADVERTENCIA/ALARMA FSM on outside runs.
module monitor_rango_consecutivo #(
    parameter int unsigned CNT_W         = 8,
    parameter int unsigned UMBRAL_ADV    = 3,
    parameter int unsigned UMBRAL_ALARMA = 6
) (
    input  logic                          clk,
    input  logic                          reset,
    monitor_rango_consecutivo_if.slave    bus
);

    localparam logic [1:0]       EST_NORMAL = 2'b00;
    localparam logic [1:0]       EST_ADV    = 2'b01;
    localparam logic [1:0]       EST_ALARMA = 2'b10;
    localparam logic [3:0]       RACHA_ADV  = 4'(UMBRAL_ADV);
    localparam logic [3:0]       RACHA_MAX  = 4'(UMBRAL_ALARMA);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [4:0]       MIN_INI    = 5'b01111;
    localparam logic [4:0]       MAX_INI    = 5'b10000;

    logic [CNT_W-1:0] r_cuenta_dentro;
    logic [CNT_W-1:0] r_cuenta_fuera;
    logic [3:0]       r_racha;
    logic [1:0]       r_estado;
    logic             r_alarma;
    logic [4:0]       r_minimo;
    logic [4:0]       r_maximo;
    logic             r_hay_datos;

    logic             w_acepta;
    logic [3:0]       w_racha_next;
    logic [1:0]       w_estado_next;
    logic             w_alarma_next;
    logic             w_menor;
    logic             w_mayor;

    // A sample arriving together with borrar is discarded.
    assign w_acepta = bus.muestra_valida & ~bus.borrar;
    assign w_menor  = $signed(bus.muestra) < $signed(r_minimo);
    assign w_mayor  = $signed(bus.muestra) > $signed(r_maximo);

    // Run length the current sample would produce, saturating at the alarm threshold.
    always_comb begin
        w_racha_next = r_racha;
        if (bus.dentro) begin
            w_racha_next = 4'd0;
        end else if (r_racha >= RACHA_MAX) begin
            w_racha_next = RACHA_MAX;
        end else begin
            w_racha_next = r_racha + 4'd1;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado <= EST_NORMAL;
        end else begin
            r_estado <= w_estado_next;
        end
    end

    // FSM next state; ALARMA is sticky until borrar/reset, code 11 recovers.
    always_comb begin
        w_estado_next = r_estado;
        if (bus.borrar) begin
            w_estado_next = EST_NORMAL;
        end else begin
            case (r_estado)
                EST_NORMAL: begin
                    if (w_acepta) begin
                        if (w_racha_next >= RACHA_MAX) begin
                            w_estado_next = EST_ALARMA;
                        end else if (w_racha_next >= RACHA_ADV) begin
                            w_estado_next = EST_ADV;
                        end
                    end
                end
                EST_ADV: begin
                    if (w_acepta) begin
                        if (w_racha_next >= RACHA_MAX) begin
                            w_estado_next = EST_ALARMA;
                        end else if (bus.dentro) begin
                            w_estado_next = EST_NORMAL;
                        end
                    end
                end
                EST_ALARMA: begin
                    w_estado_next = EST_ALARMA;
                end
                default: begin
                    w_estado_next = EST_NORMAL;
                end
            endcase
        end
    end

    // FSM output decode, registered alongside the state.
    always_comb begin
        w_alarma_next = 1'b0;
        if (w_estado_next == EST_ALARMA) begin
            w_alarma_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_alarma <= 1'b0;
        end else begin
            r_alarma <= w_alarma_next;
        end
    end

    // Counters, run length and signed extremes.
    always_ff @(posedge clk) begin
        if (reset || bus.borrar) begin
            r_cuenta_dentro <= '0;
            r_cuenta_fuera  <= '0;
            r_racha         <= 4'd0;
            r_minimo        <= MIN_INI;
            r_maximo        <= MAX_INI;
            r_hay_datos     <= 1'b0;
        end else if (bus.muestra_valida) begin
            if (bus.dentro) begin
                if (r_cuenta_dentro != CNT_MAX) begin
                    r_cuenta_dentro <= r_cuenta_dentro + CNT_W'(1);
                end
            end else begin
                if (r_cuenta_fuera != CNT_MAX) begin
                    r_cuenta_fuera <= r_cuenta_fuera + CNT_W'(1);
                end
            end
            r_racha <= w_racha_next;
            if (w_menor || !r_hay_datos) begin
                r_minimo <= bus.muestra;
            end
            if (w_mayor || !r_hay_datos) begin
                r_maximo <= bus.muestra;
            end
            r_hay_datos <= 1'b1;
        end
    end

    assign bus.cuenta_dentro = r_cuenta_dentro;
    assign bus.cuenta_fuera  = r_cuenta_fuera;
    assign bus.racha_fuera   = r_racha;
    assign bus.estado        = r_estado;
    assign bus.alarma        = r_alarma;
    assign bus.minimo        = r_minimo;
    assign bus.maximo        = r_maximo;
    assign bus.hay_datos     = r_hay_datos;

endmodule

// File: tb/tb_monitor_rango_consecutivo.sv
// Bench for monitor_rango_consecutivo: directed vector table plus randomized
// run against a reference model; a CNT_W=2 copy exercises counter saturation.
module tb_monitor_rango_consecutivo;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    monitor_rango_consecutivo_if #(.CNT_W(8)) bus_a ();
    monitor_rango_consecutivo_if #(.CNT_W(2)) bus_b ();

    monitor_rango_consecutivo #(.CNT_W(8), .UMBRAL_ADV(3), .UMBRAL_ALARMA(6)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    monitor_rango_consecutivo #(.CNT_W(2), .UMBRAL_ADV(3), .UMBRAL_ALARMA(6)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    typedef struct {
        logic       rst;
        logic       v;
        logic [4:0] m;
        logic       d;
        logic       b;
        int         cd;
        int         cf;
        int         r;
        int         e;
        int         mn;
        int         mx;
        int         hay;
    } vec_t;

    vec_t vecs[26];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state
    int m_cd, m_cf, m_racha, m_est, m_min, m_max, m_hay;

    function automatic vec_t mk(input int rst, input int v, input int m, input int d,
                                input int b, input int cd, input int cf, input int r,
                                input int e, input int mn, input int mx, input int hay);
        vec_t t;
        t.rst = 1'(rst); t.v = 1'(v); t.m = 5'(m); t.d = 1'(d); t.b = 1'(b);
        t.cd = cd; t.cf = cf; t.r = r; t.e = e; t.mn = mn; t.mx = mx; t.hay = hay;
        return t;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic chk(input string tag, input string field, input int act, input int exp);
        if (act != exp) begin
            n_err++;
            $display("FAIL %s.%s: got %0d, expected %0d", tag, field, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int cd, input int cf, input int r,
                             input int e, input int mn, input int mx, input int hay);
        n_vec++;
        chk(tag, "a.cuenta_dentro", int'(bus_a.cuenta_dentro), cd);
        chk(tag, "a.cuenta_fuera",  int'(bus_a.cuenta_fuera), cf);
        chk(tag, "a.racha_fuera",   int'(bus_a.racha_fuera), r);
        chk(tag, "a.estado",        int'(bus_a.estado), e);
        chk(tag, "a.alarma",        int'(bus_a.alarma), (e == 2) ? 1 : 0);
        chk(tag, "a.minimo",        int'($signed(bus_a.minimo)), mn);
        chk(tag, "a.maximo",        int'($signed(bus_a.maximo)), mx);
        chk(tag, "a.hay_datos",     int'(bus_a.hay_datos), hay);
        chk(tag, "b.cuenta_dentro", int'(bus_b.cuenta_dentro), imin(cd, 3));
        chk(tag, "b.cuenta_fuera",  int'(bus_b.cuenta_fuera), imin(cf, 3));
        chk(tag, "b.racha_fuera",   int'(bus_b.racha_fuera), r);
        chk(tag, "b.estado",        int'(bus_b.estado), e);
    endtask

    // Drive both DUTs identically and let one rising edge pass.
    task automatic apply(input logic rst, input logic v, input logic [4:0] m,
                         input logic d, input logic b);
        reset = rst;
        bus_a.muestra_valida = v; bus_a.muestra = m; bus_a.dentro = d; bus_a.borrar = b;
        bus_b.muestra_valida = v; bus_b.muestra = m; bus_b.dentro = d; bus_b.borrar = b;
        @(posedge clk);
        #1;
    endtask

    task automatic model_step(input logic rst, input logic v, input int m,
                              input logic d, input logic b);
        if (rst || b) begin
            m_cd = 0; m_cf = 0; m_racha = 0; m_est = 0;
            m_min = 15; m_max = -16; m_hay = 0;
        end else if (v) begin
            if (d) begin
                m_cd = imin(m_cd + 1, 255);
                m_racha = 0;
            end else begin
                m_cf = imin(m_cf + 1, 255);
                m_racha = imin(m_racha + 1, 6);
            end
            if (m_hay == 0 || m < m_min) m_min = m;
            if (m_hay == 0 || m > m_max) m_max = m;
            m_hay = 1;
            if (m_est != 2) begin
                if (m_racha >= 6)                  m_est = 2;
                else if (m_est == 0 && m_racha >= 3) m_est = 1;
                else if (m_est == 1 && d)          m_est = 0;
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus_a.muestra_valida = 1'b0; bus_a.muestra = 5'd0; bus_a.dentro = 1'b0; bus_a.borrar = 1'b0;
        bus_b.muestra_valida = 1'b0; bus_b.muestra = 5'd0; bus_b.dentro = 1'b0; bus_b.borrar = 1'b0;

        //            rst v   m  d b   cd cf r e  mn   mx  hay
        vecs[0]  = mk(1, 0,   0, 0, 0,  0, 0, 0, 0, 15, -16, 0);
        vecs[1]  = mk(0, 1,   3, 1, 0,  1, 0, 0, 0,  3,   3, 1);
        vecs[2]  = mk(0, 1,  -7, 1, 0,  2, 0, 0, 0, -7,   3, 1);
        vecs[3]  = mk(0, 1,  15, 1, 0,  3, 0, 0, 0, -7,  15, 1);
        vecs[4]  = mk(0, 1, -16, 1, 0,  4, 0, 0, 0, -16, 15, 1);
        vecs[5]  = mk(0, 1,   0, 0, 0,  4, 1, 1, 0, -16, 15, 1);
        vecs[6]  = mk(0, 1,   1, 0, 0,  4, 2, 2, 0, -16, 15, 1);
        vecs[7]  = mk(0, 1,   2, 0, 0,  4, 3, 3, 1, -16, 15, 1);
        vecs[8]  = mk(0, 1,   4, 1, 0,  5, 3, 0, 0, -16, 15, 1);
        vecs[9]  = mk(0, 0,   9, 0, 0,  5, 3, 0, 0, -16, 15, 1);
        vecs[10] = mk(0, 1,   5, 0, 0,  5, 4, 1, 0, -16, 15, 1);
        vecs[11] = mk(0, 0,  -2, 1, 0,  5, 4, 1, 0, -16, 15, 1);
        vecs[12] = mk(0, 1,   5, 0, 0,  5, 5, 2, 0, -16, 15, 1);
        vecs[13] = mk(0, 1,  -1, 0, 0,  5, 6, 3, 1, -16, 15, 1);
        vecs[14] = mk(0, 1,  -1, 0, 0,  5, 7, 4, 1, -16, 15, 1);
        vecs[15] = mk(0, 1,  -1, 0, 0,  5, 8, 5, 1, -16, 15, 1);
        vecs[16] = mk(0, 1,  -1, 0, 0,  5, 9, 6, 2, -16, 15, 1);
        vecs[17] = mk(0, 1,  -1, 0, 0,  5, 10, 6, 2, -16, 15, 1);
        vecs[18] = mk(0, 1,   1, 1, 0,  6, 10, 0, 2, -16, 15, 1);
        vecs[19] = mk(0, 1,   7, 0, 1,  0, 0, 0, 0, 15, -16, 0);
        vecs[20] = mk(0, 1,  -3, 0, 0,  0, 1, 1, 0, -3,  -3, 1);
        vecs[21] = mk(0, 1,  -3, 0, 0,  0, 2, 2, 0, -3,  -3, 1);
        vecs[22] = mk(0, 1,  -3, 0, 0,  0, 3, 3, 1, -3,  -3, 1);
        vecs[23] = mk(0, 1,  -3, 0, 0,  0, 4, 4, 1, -3,  -3, 1);
        vecs[24] = mk(1, 1,  -3, 0, 0,  0, 0, 0, 0, 15, -16, 0);
        vecs[25] = mk(0, 1,   2, 0, 0,  0, 1, 1, 0,  2,   2, 1);

        for (int i = 0; i < 26; i++) begin
            apply(vecs[i].rst, vecs[i].v, vecs[i].m, vecs[i].d, vecs[i].b);
            check_all($sformatf("vec%0d", i), vecs[i].cd, vecs[i].cf, vecs[i].r,
                      vecs[i].e, vecs[i].mn, vecs[i].mx, vecs[i].hay);
        end

        // Hand sequence: borrar held while idle, then a lone sample equal to +15.
        apply(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        check_all("seq_borrar_idle", 0, 0, 0, 0, 15, -16, 0);
        apply(1'b0, 1'b1, 5'd15, 1'b1, 1'b0);
        check_all("seq_first_max", 1, 0, 0, 0, 15, 15, 1);

        // Randomized run against the reference model, alternating biased phases.
        model_step(1'b1, 1'b0, 0, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        check_all("rnd_reset", m_cd, m_cf, m_racha, m_est, m_min, m_max, m_hay);
        for (int i = 0; i < 800; i++) begin
            logic       r_rst, r_v, r_d, r_b;
            logic [4:0] r_m;
            r_rst = ($urandom_range(0, 149) == 0);
            r_b   = ($urandom_range(0, 59) == 0);
            r_v   = ($urandom_range(0, 3) != 0);
            r_d   = ($urandom_range(0, 9) < (((i / 100) % 2) == 1 ? 2 : 7));
            r_m   = 5'($urandom_range(0, 31));
            model_step(r_rst, r_v, int'($signed(r_m)), r_d, r_b);
            apply(r_rst, r_v, r_m, r_d, r_b);
            check_all($sformatf("rnd%0d", i), m_cd, m_cf, m_racha, m_est, m_min, m_max, m_hay);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
